keypad_scan_drv: RTL and testbench
==================================

# keypad_scan_drv

Scanned 4x4 matrix keypad reader for the countdown-timer user input, the input-side counterpart of the multiplexed 7-segment display path. It drives zero-hot column strobes at the shared scan-tick rate and samples the active-low row lines. It debounces whole scan frames and reports each clean key press once as a 4-bit code with a one-cycle valid strobe, plus a held-key level.

## Interface
- DEBOUNCE_FRAMES, 3: consecutive identical full frames required to accept a press or a release; legal range 2..15.
- CLK  input  1  system clock; all state updates on posedge.
- CLR  input  1  reset, asynchronous, active-high.
- CE  input  1  scan tick; one column step per CLK cycle with CE=1. Pulses are at least 4 CLK cycles apart.
- ROW  input  4  raw keypad rows, active-low, externally pulled up, asynchronous to CLK.
- COL  output  4  column strobes, zero-hot; bit c low selects column c.
- KEY  output  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
- KV  output  1  key-valid strobe, high for exactly one CLK cycle per accepted press.
- PRESSED  output  1  high while an accepted key is held, until its release is accepted.

## Operation
- ROW passes through a 2-FF synchronizer before any use; no other logic touches raw ROW.
- Column index col_idx starts at 0 (COL=4'b1110). On each CE:
  - the synchronized ROW is captured as the sample for the current column;
  - the column then advances: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Frame = 4 consecutive column samples, ending with the column-3 capture. Frame result:
  - NONE: all rows high in all 4 samples;
  - SINGLE(k): exactly one low row bit across the frame, k = {row of that bit, column};
  - MULTI: more than one low bit. This covers ghosting; MULTI is never reported.
- FSM, evaluated only at frame end. cnt is a 4-bit counter; cand is the 4-bit candidate code.
  - IDLE: SINGLE(k) -> DEB_PRESS, cand=k, cnt=1. Otherwise stay.
  - DEB_PRESS:
    - SINGLE(cand): cnt+1; at cnt==DEBOUNCE_FRAMES -> HELD, KEY<=cand, KV pulse, PRESSED<=1.
    - SINGLE(other k): cand=k, cnt=1.
    - NONE or MULTI: -> IDLE.
  - HELD: NONE -> DEB_REL, cnt=1. SINGLE or MULTI of any key: stay. No auto-repeat; a second key held alongside is ignored.
  - DEB_REL:
    - NONE: cnt+1; at cnt==DEBOUNCE_FRAMES -> IDLE, PRESSED<=0.
    - any non-NONE: -> HELD; PRESSED stays 1, no KV.
- KEY holds its value until the next accepted press. It does not change on release.

## Timing
- Reset values: COL=4'b1110, KEY=4'h0, KV=0, PRESSED=0, FSM=IDLE, cnt=0, cand=0, synchronizer and frame accumulators cleared.
- CLR asserted mid-frame discards the partial frame and all debounce progress. Scanning restarts at column 0 on the first CE after CLR deasserts.
- CLR and CE in the same cycle: CLR wins.
- ROW-to-sample latency is 2 CLK cycles (synchronizer). The 4-cycle CE spacing guarantees that each sample reflects the column driven since the previous CE.
- KV and PRESSED rise on the CLK edge that follows the frame-completing CE. KV falls on the next edge.
- Minimum press latency: DEBOUNCE_FRAMES full frames. A press starting mid-frame first counts at the next full frame.
- CE idle: all state freezes. COL holds.

## Structure
- Shared package: FSM state encoding (IDLE, DEB_PRESS, HELD, DEB_REL), KEY_W=4, NCOL=4, NROW=4.
- Column driver: one RING_CNT instance with BITS_NUM=4 and ACT_STATE=0. Its cleared state is 4'b1110 and it advances on CE.
- Frame accumulation, result classification and the FSM stay in this module.

## Test plan
All scenarios use DEBOUNCE_FRAMES=3 and CE every 4 CLK cycles.
- Reset: assert CLR during column 2 while row 0 is low -> COL=1110, KEY=0, KV=0, PRESSED=0. After release, no KV until 3 full new frames.
- Clean press: row 1 low while column 2 is strobed, held 5 frames -> exactly one KV, KEY=4'h6, PRESSED=1 after frame 3, no further KV.
- Bounce: key 4'h6 present 2 frames, absent 1, present 3 -> a single KV, at the end of the 3rd consecutive frame.
- Ghost: row 0/column 0 and row 2/column 3 low together for 6 frames -> no KV, PRESSED=0, KEY unchanged.
- Release debounce: from HELD, key absent 2 frames then back -> PRESSED stays 1, no KV. Then absent 3 frames -> PRESSED=0, KEY still 4'h6.
- Candidate switch: key 4'h5 for 2 frames, then key 4'h9 for 3 frames -> one KV with KEY=4'h9, no KV for 4'h5.

Source files
------------

// File: rtl/keypad_scan_drv_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// The helpers count and locate asserted bits in the scan samples.
package keypad_scan_drv_pkg;

    localparam int KEY_W = 4;
    localparam int NCOL  = 4;
    localparam int NROW  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    // Number of set bits, saturated at 2; above one only "many" matters.
    function automatic logic [1:0] count_sat(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
        return (n > 3'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest set bit.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_drv_ring_cnt.sv
// Rotating one-active ring counter; the active bit starts at bit 0 and
// moves one position up on every enabled clock.
module keypad_scan_drv_ring_cnt #(
    parameter int   BITS_NUM  = 4,
    parameter logic ACT_STATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    output logic [BITS_NUM-1:0] q
);

    localparam logic [BITS_NUM-1:0] CLEARED = {{(BITS_NUM-1){~ACT_STATE}}, ACT_STATE};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= CLEARED;
        else if (ce)
            q <= {q[BITS_NUM-2:0], q[BITS_NUM-1]};
    end

endmodule

// File: rtl/keypad_scan_drv.sv
// 4x4 keypad scanner: strobes columns, classifies whole frames and debounces
// them into a one-shot key-valid strobe plus a held-key level.
//
//   state     | meaning
//   IDLE      | no key accepted, waiting for a single-key frame
//   DEB_PRESS | counting identical single-key frames for cand
//   HELD      | key accepted and still down
//   DEB_REL   | counting empty frames before declaring release
module keypad_scan_drv
    import keypad_scan_drv_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic [NROW-1:0]  ROW,
    output logic [NCOL-1:0]  COL,
    output logic [KEY_W-1:0] KEY,
    output logic             KV,
    output logic             PRESSED
);

    logic [NROW-1:0]  row_meta, row_sync;
    logic [1:0]       col_idx;
    logic [NROW-1:0]  row_low;
    logic [1:0]       cur_cnt, acc_cnt, frame_cnt;
    logic [2:0]       cnt_sum;
    logic [KEY_W-1:0] cur_key, acc_key, frame_key;
    logic             frame_end, frame_none, frame_single;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] cand_q, cand_d, key_d;
    logic             kv_d, pressed_d;

    keypad_scan_drv_ring_cnt #(
        .BITS_NUM (NCOL),
        .ACT_STATE(1'b0)
    ) u_col_ring (
        .clk(CLK),
        .rst(CLR),
        .ce (CE),
        .q  (COL)
    );

    // Synchronizer clears to all-high so reset never looks like a press.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
        end
    end

    assign col_idx   = low_index(~COL);
    assign row_low   = ~row_sync;
    assign cur_cnt   = count_sat(row_low);
    assign cur_key   = {low_index(row_low), col_idx};
    assign cnt_sum   = {1'b0, acc_cnt} + {1'b0, cur_cnt};
    assign frame_cnt = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    assign frame_key = (acc_cnt != 2'd0) ? acc_key : cur_key;
    assign frame_end = CE && (col_idx == 2'd3);
    assign frame_none   = (frame_cnt == 2'd0);
    assign frame_single = (frame_cnt == 2'd1);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            acc_cnt <= '0;
            acc_key <= '0;
        end else if (CE) begin
            if (frame_end) begin
                acc_cnt <= '0;
                acc_key <= '0;
            end else begin
                acc_cnt <= frame_cnt;
                if (acc_cnt == 2'd0)
                    acc_key <= cur_key;
            end
        end
    end

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        key_d     = KEY;
        kv_d      = 1'b0;
        pressed_d = PRESSED;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        state_d = DEB_PRESS;
                        cand_d  = frame_key;
                        cnt_d   = 4'd1;
                    end
                end
                DEB_PRESS: begin
                    if (frame_single && frame_key == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(DEBOUNCE_FRAMES)) begin
                            state_d   = HELD;
                            key_d     = cand_q;
                            kv_d      = 1'b1;
                            pressed_d = 1'b1;
                        end
                    end else if (frame_single) begin
                        cand_d = frame_key;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frame_none) begin
                        state_d = DEB_REL;
                        cnt_d   = 4'd1;
                    end
                end
                DEB_REL: begin
                    if (frame_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(DEBOUNCE_FRAMES)) begin
                            state_d   = IDLE;
                            pressed_d = 1'b0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            KEY     <= '0;
            KV      <= 1'b0;
            PRESSED <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            KEY     <= key_d;
            KV      <= kv_d;
            PRESSED <= pressed_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_drv.sv
// Directed bench for keypad_scan_drv: a keypad model derives ROW from COL
// and the set of held keys; each scenario task checks its own results.
module tb_keypad_scan_drv;

    logic       clk = 1'b0;
    logic       clr;
    logic       ce;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       kv;
    logic       pressed;

    logic [15:0] keys;
    int          kv_count = 0;
    int          n_pass   = 0;
    int          n_checks = 0;

    keypad_scan_drv #(.DEBOUNCE_FRAMES(3)) dut (
        .CLK    (clk),
        .CLR    (clr),
        .CE     (ce),
        .ROW    (row),
        .COL    (col),
        .KEY    (key),
        .KV     (kv),
        .PRESSED(pressed)
    );

    always #5 clk = ~clk;

    // Counts KV-high cycles, so a stretched strobe shows up as an extra count.
    always @(posedge clk) if (kv === 1'b1) kv_count <= kv_count + 1;

    function automatic logic [3:0] row_model(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (k[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    task automatic set_keys(input logic [15:0] k);
        keys = k;
        row  = row_model(keys, col);
    endtask

    task automatic step();
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
        row = row_model(keys, col);
        repeat (2) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < 4 * n; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        int kv0;
        clr = 1'b1; ce = 1'b0; set_keys(16'h0000);
        repeat (3) @(negedge clk);
        n_checks++; if (col !== 4'b1110) $display("FAIL reset_col: got %b want 1110", col); else n_pass++;
        n_checks++; if (key !== 4'h0) $display("FAIL reset_key: got %h want 0", key); else n_pass++;
        n_checks++; if (kv !== 1'b0) $display("FAIL reset_kv: got %b want 0", kv); else n_pass++;
        n_checks++; if (pressed !== 1'b0) $display("FAIL reset_pressed: got %b want 0", pressed); else n_pass++;
        clr = 1'b0;
        set_keys(16'h0004);
        frames(2); step(); step();
        n_checks++; if (col !== 4'b1011) $display("FAIL midframe_col: got %b want 1011", col); else n_pass++;
        @(negedge clk) clr = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (col !== 4'b1110) $display("FAIL clr_col: got %b want 1110", col); else n_pass++;
        n_checks++; if (key !== 4'h0) $display("FAIL clr_key: got %h want 0", key); else n_pass++;
        n_checks++; if (pressed !== 1'b0) $display("FAIL clr_pressed: got %b want 0", pressed); else n_pass++;
        clr = 1'b0;
        row = row_model(keys, col);
        kv0 = kv_count;
        frames(2);
        n_checks++; if (kv_count !== kv0) $display("FAIL clr_early_kv: got %0d want %0d", kv_count, kv0); else n_pass++;
        frames(1);
        n_checks++; if (kv_count !== kv0 + 1) $display("FAIL clr_kv: got %0d want %0d", kv_count, kv0 + 1); else n_pass++;
        n_checks++; if (key !== 4'h2) $display("FAIL clr_key2: got %h want 2", key); else n_pass++;
        set_keys(16'h0000);
        frames(3);
        n_checks++; if (pressed !== 1'b0) $display("FAIL clr_release: got %b want 0", pressed); else n_pass++;
    endtask

    task automatic test_clean_press();
        int kv0;
        kv0 = kv_count;
        set_keys(16'h0040);
        frames(2);
        n_checks++; if (kv_count !== kv0) $display("FAIL clean_early_kv: got %0d want %0d", kv_count, kv0); else n_pass++;
        n_checks++; if (pressed !== 1'b0) $display("FAIL clean_early_pressed: got %b want 0", pressed); else n_pass++;
        frames(1);
        n_checks++; if (kv_count !== kv0 + 1) $display("FAIL clean_kv: got %0d want %0d", kv_count, kv0 + 1); else n_pass++;
        n_checks++; if (key !== 4'h6) $display("FAIL clean_key: got %h want 6", key); else n_pass++;
        n_checks++; if (pressed !== 1'b1) $display("FAIL clean_pressed: got %b want 1", pressed); else n_pass++;
        frames(2);
        n_checks++; if (kv_count !== kv0 + 1) $display("FAIL clean_no_repeat: got %0d want %0d", kv_count, kv0 + 1); else n_pass++;
        set_keys(16'h0000);
        frames(3);
        n_checks++; if (pressed !== 1'b0) $display("FAIL clean_release: got %b want 0", pressed); else n_pass++;
    endtask

    task automatic test_bounce();
        int kv0;
        kv0 = kv_count;
        set_keys(16'h0040); frames(2);
        set_keys(16'h0000); frames(1);
        set_keys(16'h0040); frames(2);
        n_checks++; if (kv_count !== kv0) $display("FAIL bounce_early_kv: got %0d want %0d", kv_count, kv0); else n_pass++;
        frames(1);
        n_checks++; if (kv_count !== kv0 + 1) $display("FAIL bounce_kv: got %0d want %0d", kv_count, kv0 + 1); else n_pass++;
        n_checks++; if (pressed !== 1'b1) $display("FAIL bounce_pressed: got %b want 1", pressed); else n_pass++;
    endtask

    task automatic test_release_debounce();
        int kv0;
        kv0 = kv_count;
        set_keys(16'h0000); frames(2);
        set_keys(16'h0040); frames(1);
        n_checks++; if (pressed !== 1'b1) $display("FAIL rel_bounce_pressed: got %b want 1", pressed); else n_pass++;
        n_checks++; if (kv_count !== kv0) $display("FAIL rel_bounce_kv: got %0d want %0d", kv_count, kv0); else n_pass++;
        set_keys(16'h0000); frames(2);
        n_checks++; if (pressed !== 1'b1) $display("FAIL rel_early_pressed: got %b want 1", pressed); else n_pass++;
        frames(1);
        n_checks++; if (pressed !== 1'b0) $display("FAIL rel_pressed: got %b want 0", pressed); else n_pass++;
        n_checks++; if (key !== 4'h6) $display("FAIL rel_key: got %h want 6", key); else n_pass++;
    endtask

    task automatic test_ghost();
        int kv0;
        kv0 = kv_count;
        set_keys(16'h0801);
        frames(6);
        n_checks++; if (kv_count !== kv0) $display("FAIL ghost_kv: got %0d want %0d", kv_count, kv0); else n_pass++;
        n_checks++; if (pressed !== 1'b0) $display("FAIL ghost_pressed: got %b want 0", pressed); else n_pass++;
        n_checks++; if (key !== 4'h6) $display("FAIL ghost_key: got %h want 6", key); else n_pass++;
        set_keys(16'h0000); frames(1);
    endtask

    task automatic test_candidate_switch();
        int kv0;
        kv0 = kv_count;
        set_keys(16'h0020); frames(2);
        set_keys(16'h0200); frames(2);
        n_checks++; if (kv_count !== kv0) $display("FAIL cand_early_kv: got %0d want %0d", kv_count, kv0); else n_pass++;
        frames(1);
        n_checks++; if (kv_count !== kv0 + 1) $display("FAIL cand_kv: got %0d want %0d", kv_count, kv0 + 1); else n_pass++;
        n_checks++; if (key !== 4'h9) $display("FAIL cand_key: got %h want 9", key); else n_pass++;
        set_keys(16'h0000); frames(3);
        n_checks++; if (pressed !== 1'b0) $display("FAIL cand_release: got %b want 0", pressed); else n_pass++;
    endtask

    task automatic test_ce_idle();
        step();
        n_checks++; if (col !== 4'b1101) $display("FAIL idle_col_step: got %b want 1101", col); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++; if (col !== 4'b1101) $display("FAIL idle_col_hold: got %b want 1101", col); else n_pass++;
        step(); step(); step();
        n_checks++; if (col !== 4'b1110) $display("FAIL idle_col_wrap: got %b want 1110", col); else n_pass++;
    endtask

    initial begin
        clr = 1'b1;
        ce  = 1'b0;
        keys = '0;
        row = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_debounce();
        test_ghost();
        test_candidate_switch();
        test_ce_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
